run_ctrl: RTL and testbench

Host-side run sequencer that sits directly upstream of the processor top level. It owns the processor's `reset` and `req` inputs and watches its `done` output. A host `start` makes it hold the core in reset, issue a one-cycle request, count execution cycles until `done` (or a timeout), and present the result until the host acknowledges it.

---
 rtl/run_ctrl.sv | 91 +++++++++
 tb/tb_run_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: host run sequencer for the core (reset hold, one-shot req, RUN cycle count, result hold).
// Define RUN_CTRL_TIMEOUT_EN to end RUN after TIMEOUT cycles; otherwise cycles saturates and RUN waits for core_done.
module run_ctrl #(
    parameter int RST_CYC = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic             core_done,
    output logic             core_reset,
    output logic             core_req,
    output logic             busy,
    output logic             result_valid,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycles
);
    localparam int RW = $clog2(RST_CYC) + 1;
`ifndef RUN_CTRL_TIMEOUT_EN
    localparam int unused_timeout = TIMEOUT;
`endif
    typedef enum logic [2:0] {IDLE, RST, REQ, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [RW-1:0]    rcnt, rcnt_nx;
    logic [CNT_W-1:0] cycles_nx;
    logic             to_nx;
    always_comb begin
        state_nx  = state;
        rcnt_nx   = rcnt;
        cycles_nx = cycles;
        to_nx     = timed_out;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = RST;
                    rcnt_nx   = '0;
                    cycles_nx = '0;
                    to_nx     = 1'b0;
                end else if (ack && state == DONE) begin
                    state_nx = IDLE;
                    to_nx    = 1'b0;
                end
            end
            RST: begin
                state_nx = rcnt == RW'(RST_CYC - 1) ? REQ : RST;
                rcnt_nx  = rcnt + RW'(1);
            end
            REQ: state_nx = RUN;
            RUN: begin
                if (core_done)
                    state_nx = DONE;
`ifdef RUN_CTRL_TIMEOUT_EN
                else if (cycles == CNT_W'(TIMEOUT - 1)) begin
                    cycles_nx = CNT_W'(TIMEOUT);
                    to_nx     = 1'b1;
                    state_nx  = DONE;
                end else
                    cycles_nx = cycles + CNT_W'(1);
`else
                else
                    cycles_nx = &cycles ? cycles : cycles + CNT_W'(1);
`endif
            end
            default: state_nx = IDLE;
        endcase
    end
    // outputs are decoded from the next state so every port is a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rcnt         <= '0;
            cycles       <= '0;
            timed_out    <= 1'b0;
            core_reset   <= 1'b1;
            core_req     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            rcnt         <= rcnt_nx;
            cycles       <= cycles_nx;
            timed_out    <= to_nx;
            core_reset   <= state_nx inside {IDLE, RST, DONE};
            core_req     <= state_nx == REQ;
            busy         <= state_nx inside {RST, REQ, RUN};
            result_valid <= state_nx == DONE;
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized scoreboard bench for run_ctrl; honours RUN_CTRL_TIMEOUT_EN in its reference model.
module tb_run_ctrl;
    localparam int RST_CYC = 2;
    localparam int CNT_W   = 8;
    localparam int TO      = 20;
    localparam int CAP     = 255;
    typedef struct {
        int cyc;
        bit to;
    } res_t;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, ack = 1'b0, core_done = 1'b0;
    logic core_reset, core_req, busy, result_valid, timed_out;
    logic [CNT_W-1:0] cycles;
    int   n_cmp = 0, n_bad = 0;
    res_t sb[$];
    res_t last;
    logic rv_q = 1'b0;
    bit   in_done = 1'b0;
    run_ctrl #(.RST_CYC(RST_CYC), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack), .core_done(core_done),
        .core_reset(core_reset), .core_req(core_req), .busy(busy),
        .result_valid(result_valid), .timed_out(timed_out), .cycles(cycles)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // d = number of RUN edges before core_done is first sampled high
    function automatic res_t model(input int d);
        res_t r;
`ifdef RUN_CTRL_TIMEOUT_EN
        r.cyc = d >= TO ? TO : d;
        r.to  = d >= TO;
`else
        r.cyc = d > CAP ? CAP : d;
        r.to  = 1'b0;
`endif
        return r;
    endfunction
    always @(negedge clk) begin
        res_t e;
        if (result_valid === 1'b1 && rv_q !== 1'b1) begin
            if (sb.size() == 0)
                chk("unexpected_result", 1, 0);
            else begin
                e = sb.pop_front();
                chk("sb_cycles", 32'(cycles), 32'(e.cyc));
                chk("sb_timed_out", 32'(timed_out), 32'(e.to));
                chk("sb_busy_done", 32'(busy), 0);
                chk("sb_core_reset_done", 32'(core_reset), 1);
            end
        end
        rv_q = result_valid;
    end
    task automatic launch(input int d, input bit stale, input bit with_ack);
        start     = 1'b1;
        ack       = with_ack;
        core_done = stale;
        sb.push_back(model(d));
        @(negedge clk);
        ack = 1'b0;
        chk("busy_on_start", 32'(busy), 1);
        chk("cycles_clear", 32'(cycles), 0);
        chk("rv_clear", 32'(result_valid), 0);
        chk("to_clear", 32'(timed_out), 0);
        for (int j = 0; j <= RST_CYC + 1; j++) begin
            if (j > 0) @(negedge clk);
            chk("core_req", 32'(core_req), 32'(j == RST_CYC));
            chk("core_reset", 32'(core_reset), 32'(j < RST_CYC));
            start = (j <= RST_CYC) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask
    task automatic run_phase(input int d);
        res_t e, p;
        e = model(d);
        p = model(100);
        for (int i = 0; i <= d; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 100) begin
                chk("cycles_at_100", 32'(cycles), 32'(p.cyc));
                chk("busy_at_100", 32'(busy), 32'(!p.to));
            end
            core_done = (i == d);
            start     = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        start     = 1'b0;
        core_done = 1'($urandom_range(0, 1));
        for (int w = 0; w < 8 && result_valid !== 1'b1; w++) @(negedge clk);
        chk("result_valid", 32'(result_valid), 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("cycles_frozen", 32'(cycles), 32'(e.cyc));
        last = e;
    endtask
    task automatic finish_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("rv_after_ack", 32'(result_valid), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("core_reset_idle", 32'(core_reset), 1);
        chk("to_idle", 32'(timed_out), 0);
        chk("cycles_kept", 32'(cycles), 32'(last.cyc));
        if ($urandom_range(0, 1) == 1) begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            chk("ack_idle_rv", 32'(result_valid), 0);
            chk("ack_idle_busy", 32'(busy), 0);
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int ds[$];
        ds = '{10, 0, 1, 19, 20, 21, 300, 256};
        repeat (6) ds.push_back(int'($urandom_range(0, 40)));
        #1 reset = 1'b0;
        #1;
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_core_req", 32'(core_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rv", 32'(result_valid), 0);
        chk("rst_to", 32'(timed_out), 0);
        chk("rst_cycles", 32'(cycles), 0);
        @(negedge clk);
        reset = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 0);
        chk("idle_ack_rv", 32'(result_valid), 0);
        foreach (ds[n]) begin
            if (in_done && $urandom_range(0, 1) == 1)
                launch(ds[n], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else begin
                if (in_done) finish_ack();
                launch(ds[n], 1'($urandom_range(0, 1)), 1'b0);
            end
            run_phase(ds[n]);
            in_done = 1'b1;
        end
        finish_ack();
        launch(50, 1'b0, 1'b0);
        core_done = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_core_reset", 32'(core_reset), 1);
        chk("async_core_req", 32'(core_req), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_rv", 32'(result_valid), 0);
        chk("async_to", 32'(timed_out), 0);
        chk("async_cycles", 32'(cycles), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_core_reset", 32'(core_reset), 1);
        chk("post_rst_rv", 32'(result_valid), 0);
        launch(12, 1'b1, 1'b0);
        run_phase(12);
        finish_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
